// File: rtl/upuart_fifo_ext.sv
// upuart_fifo_ext
//   UART FIFO with a show-ahead read port, occupancy threshold, flush and
//   sticky overflow/underflow flags. One instance serves the TX path and one
//   serves the RX path.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   data_in, wr       write word / write request
//   data_out, rd      head word (combinational from rd_p) / pop request
//   flush             discard contents; wins over rd/wr, loses to rst
//   thr               occupancy threshold compared against count
//   clr_err           clear sticky ovf/udf (a same-cycle set wins)
//   count, free       words stored / DEPTH - count
//   full, empty       count == DEPTH / count == 0
//   thr_hit           count >= thr
//   ovf, udf          sticky: write dropped / read on empty
module upuart_fifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_POW2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rd,
  input  logic                  flush,
  input  logic [DEPTH_POW2:0]   thr,
  input  logic                  clr_err,
  output logic [DEPTH_POW2:0]   count,
  output logic [DEPTH_POW2:0]   free,
  output logic                  full,
  output logic                  empty,
  output logic                  thr_hit,
  output logic                  ovf,
  output logic                  udf
);

  localparam int AW = DEPTH_POW2;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]         rd_p, wr_p;
  logic [AW:0]           cnt;
  logic                  rd_ok, wr_ok, ovf_set, udf_set;

  assign count    = cnt;
  assign full     = (cnt == DEPTH_V);
  assign empty    = (cnt == '0);
  assign free     = DEPTH_V - cnt;
  // thr wider than DEPTH can never be reached, so thr_hit stays low.
  assign thr_hit  = (cnt >= thr);
  assign data_out = mem[rd_p];

  // A pop frees the slot in the same cycle, so a full FIFO still takes a
  // write alongside a read. Flush swallows both requests.
  assign rd_ok = rd & ~empty & ~flush;
  assign wr_ok = wr & (~full | rd_ok) & ~flush;

  // rd+wr on empty is a plain write, not an underflow.
  assign udf_set = rd & empty & ~wr & ~flush;
  assign ovf_set = wr & full & ~rd_ok & ~flush;

  // Storage is not reset; words only become visible through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_p] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p <= '0;
      wr_p <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (flush) begin
        rd_p <= '0;
        wr_p <= '0;
        cnt  <= '0;
      end else begin
        if (rd_ok) rd_p <= rd_p + AW'(1);
        if (wr_ok) wr_p <= wr_p + AW'(1);
        cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (clr_err) udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upuart_fifo_ext.sv
// tb_upuart_fifo_ext
//   Directed bench for upuart_fifo_ext at DATA_WIDTH=8, DEPTH_POW2=2 (DEPTH=4).
module tb_upuart_fifo_ext;

  logic       clk = 1'b0;
  logic       rst, wr, rd, flush, clr_err;
  logic [7:0] data_in, data_out;
  logic [2:0] thr, count, free;
  logic       full, empty, thr_hit, ovf, udf;

  int checks = 0;
  int errors = 0;

  upuart_fifo_ext #(.DATA_WIDTH(8), .DEPTH_POW2(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr(wr), .data_out(data_out),
    .rd(rd), .flush(flush), .thr(thr), .clr_err(clr_err), .count(count),
    .free(free), .full(full), .empty(empty), .thr_hit(thr_hit),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // One clock with the given requests, then release them; outputs are
  // settled #1 after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; data_in = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1; thr = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (free !== 3'd4) begin errors++; $display("FAIL reset_free got=%0d exp=4", free); end
    checks++; if ({full, empty, ovf, udf, thr_hit} !== 5'b01001) begin errors++; $display("FAIL reset_flags got=%b exp=01001", {full, empty, ovf, udf, thr_hit}); end
  endtask

  task automatic test_fill_drain;
    logic [7:0] exp_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, exp_v[i]);
    checks++; if ({full, count, free} !== {1'b1, 3'd4, 3'd0}) begin errors++; $display("FAIL fill_state full=%b count=%0d free=%0d exp 1/4/0", full, count, free); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== exp_v[i]) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, exp_v[i]); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if ({empty, ovf, udf} !== 3'b100) begin errors++; $display("FAIL drain_end empty/ovf/udf got=%b exp=100", {empty, ovf, udf}); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, exp_v[i]);
    cyc(1'b1, 1'b0, 8'h55);
    checks++; if ({ovf, count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL ovf_set ovf=%b count=%0d exp 1/4", ovf, count); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== exp_v[i]) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, data_out, exp_v[i]); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_rdwr;
    logic [7:0] q [$];
    logic [7:0] exp_v [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h11 * (i + 1));
    cyc(1'b1, 1'b1, 8'h66);
    checks++; if ({count, full, data_out} !== {3'd4, 1'b1, 8'h22}) begin errors++; $display("FAIL full_rdwr count=%0d full=%b data=%h exp 4/1/22", count, full, data_out); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== exp_v[i]) begin errors++; $display("FAIL full_rdwr_drain[%0d] got=%h exp=%h", i, data_out, exp_v[i]); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    // Six rd+wr cycles at full depth walk both pointers past the wrap.
    for (int i = 0; i < 4; i++) begin cyc(1'b1, 1'b0, 8'hB0 + 8'(i)); q.push_back(8'hB0 + 8'(i)); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (data_out !== q[0]) begin errors++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, data_out, q[0]); end
      cyc(1'b1, 1'b1, 8'hC0 + 8'(i));
      void'(q.pop_front()); q.push_back(8'hC0 + 8'(i));
    end
    checks++; if ({count, full} !== {3'd4, 1'b1}) begin errors++; $display("FAIL wrap_count count=%0d full=%b exp 4/1", count, full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_out !== q[0]) begin errors++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, data_out, q[0]); end
      cyc(1'b0, 1'b1, 8'h00); void'(q.pop_front());
    end
  endtask

  task automatic test_empty_rdwr;
    cyc(1'b1, 1'b1, 8'h77);
    checks++; if ({count, udf, data_out} !== {3'd1, 1'b0, 8'h77}) begin errors++; $display("FAIL empty_rdwr count=%0d udf=%b data=%h exp 1/0/77", count, udf, data_out); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if ({count, udf} !== {3'd0, 1'b0}) begin errors++; $display("FAIL udf_first_rd count=%0d udf=%b exp 0/0", count, udf); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if ({count, udf} !== {3'd0, 1'b1}) begin errors++; $display("FAIL udf_set count=%0d udf=%b exp 0/1", count, udf); end
    // Set beats clear in the same cycle.
    clr_err = 1'b1; cyc(1'b0, 1'b1, 8'h00);
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_set_prio got=%b exp=1", udf); end
    cyc(1'b0, 1'b0, 8'h00); clr_err = 1'b0;
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", udf); end
  endtask

  task automatic test_threshold;
    logic exp_h [3] = '{1'b0, 1'b0, 1'b1};
    thr = 3'd3;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'hD0 + 8'(i));
      checks++; if (thr_hit !== exp_h[i]) begin errors++; $display("FAIL thr3_wr[%0d] got=%b exp=%b", i, thr_hit, exp_h[i]); end
    end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (thr_hit !== 1'b0) begin errors++; $display("FAIL thr3_fall got=%b exp=0", thr_hit); end
    cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b1, 8'h00);
    thr = 3'd0; #1;
    checks++; if ({empty, thr_hit} !== 2'b11) begin errors++; $display("FAIL thr0_empty empty/hit got=%b exp=11", {empty, thr_hit}); end
    thr = 3'd5;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hE0 + 8'(i));
    checks++; if ({full, thr_hit} !== 2'b10) begin errors++; $display("FAIL thr5_full full/hit got=%b exp=10", {full, thr_hit}); end
    thr = 3'd4; #1;
    checks++; if (thr_hit !== 1'b1) begin errors++; $display("FAIL thr4_full got=%b exp=1", thr_hit); end
  endtask

  task automatic test_flush_reset;
    // Arrive full from the threshold test: flush, then raise udf.
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hF0 + 8'(i));
    checks++; if ({count, udf, ovf} !== {3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL pre_flush count=%0d udf=%b ovf=%b exp 3/1/0", count, udf, ovf); end
    flush = 1'b1; cyc(1'b1, 1'b1, 8'hAA); flush = 1'b0;
    checks++; if ({count, empty, udf, ovf} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL flush count=%0d empty=%b udf=%b ovf=%b exp 0/1/1/0", count, empty, udf, ovf); end
    cyc(1'b1, 1'b0, 8'h99);
    checks++; if ({count, data_out} !== {3'd1, 8'h99}) begin errors++; $display("FAIL post_flush_wr count=%0d data=%h exp 1/99", count, data_out); end
    cyc(1'b1, 1'b0, 8'h9A);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    checks++; if ({count, free, ovf, udf, empty} !== {3'd0, 3'd4, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL rst_mid count=%0d free=%0d ovf=%b udf=%b empty=%b exp 0/4/0/0/1", count, free, ovf, udf, empty); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    data_in = 8'h00; thr = 3'd0;
    test_reset;
    test_fill_drain;
    test_overflow;
    test_full_rdwr;
    test_empty_rdwr;
    test_threshold;
    test_flush_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
